hilo_div_unit: RTL
==================

HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 hilo_mode_wb  in  2  WB-stage HILO write: 00 none, 01 LO<=rdata1_wb, 10 HI<=rdata1_wb, 11 {HI,LO}<={alu_r2_wb,alu_r1_wb}.
REQ-005 rdata1_wb  in  32  MTHI/MTLO source operand.
REQ-006 alu_r1_wb  in  32  LO result of MULT/MULTU/DIV/DIVU.
REQ-007 alu_r2_wb  in  32  HI result of MULT/MULTU/DIV/DIVU.
REQ-008 div_start  in  1  request a division; sampled only in IDLE.
REQ-009 div_signed  in  1  1 = DIV, 0 = DIVU; captured with div_start.
REQ-010 div_a  in  32  dividend; captured with div_start.
REQ-011 div_b  in  32  divisor; captured with div_start.
REQ-012 div_cancel  in  1  pipeline flush; aborts any division in progress.
REQ-013 div_busy  out  1  high in CALC and FIX states.
REQ-014 div_done  out  1  one-cycle pulse, result valid.
REQ-015 div_quot  out  32  quotient, held until next accepted start.
REQ-016 div_rem  out  32  remainder, held until next accepted start.
REQ-017 hilo  out  64  registered {HI,LO}, feeds the ID-stage HILO forwarding path.

Function
REQ-018 HILO SHALL update on the clock edge per hilo_mode_wb; an unwritten half SHALL hold its value; the new value SHALL be visible on hilo the cycle after the write.
REQ-019 Divider states SHALL be IDLE, CALC, FIX, DONE; transitions: IDLE->CALC on div_start; CALC->FIX after exactly 32 iterations; FIX->DONE; DONE->IDLE.
REQ-020 Start accepted in cycle T SHALL give div_done=1 in cycle T+34 only; div_busy SHALL be 1 in cycles T+1..T+33.
REQ-021 CALC SHALL perform restoring division on operand magnitudes, one quotient bit per cycle, using a 33-bit partial remainder.
REQ-022 FIX SHALL negate the quotient when div_signed and sign(a)!=sign(b), and SHALL negate the remainder when div_signed and a is negative.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0, with no exception raised.
REQ-024 Divisor zero SHALL return quotient 0xFFFFFFFF and remainder equal to div_a, with the same 34-cycle latency.
REQ-025 div_start outside IDLE SHALL be ignored.
REQ-026 div_cancel in any state SHALL force IDLE at the next edge, suppress div_done, and leave div_quot/div_rem unchanged.
REQ-027 div_cancel SHALL take priority over div_start in the same cycle.
REQ-028 HILO writes and divider operation SHALL be independent; the divider SHALL never write HILO directly.

Reset
REQ-029 While resetn=0 the block SHALL hold hilo=0, state=IDLE, div_busy=0, div_done=0, div_quot=0, div_rem=0, iteration counter=0.
REQ-030 Reset asserted mid-division SHALL abort the division with no div_done after release.

Structure
REQ-031 HILO mode encodings and divider state encodings SHALL be constants in the shared CPU definitions package.
REQ-032 The iterative divider (REQ-019..027) SHALL be the sub-module div_iter; the HILO register SHALL remain in hilo_div_unit.

Verification
REQ-033 Unsigned 7/2 started at T -> div_done only at T+34, quot=3, rem=1, div_busy low at T+34.
REQ-034 Signed 0xFFFFFFF9/2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-035 div_b=0, div_a=0x1234 -> quot=0xFFFFFFFF, rem=0x1234 at T+34.
REQ-036 div_cancel at T+10 together with div_start -> IDLE at T+11, no div_done, outputs keep previous result; a new start at T+12 completes at T+46.
REQ-037 hilo_mode_wb=10 with rdata1_wb=0xA5A5A5A5, then 11 with {0x1,0x2} -> hilo=0xA5A5A5A5_00000000, then 0x00000001_00000002, each visible the cycle after the write.
REQ-038 resetn low at T+20 of a division -> all outputs 0 immediately; no div_done after release.

Source files
------------

// File: rtl/hilo_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit_pkg
// Description : Shared CPU definitions for the HILO register and the
//               iterative divider: HILO write-mode encodings, divider state
//               encodings, iteration count and a two's-complement helper.
// Revision    : 1.0  initial release
// ============================================================================
package hilo_div_unit_pkg;

    // WB-stage HILO write modes
    localparam logic [1:0] C_HILO_NONE = 2'b00;
    localparam logic [1:0] C_HILO_LO   = 2'b01;
    localparam logic [1:0] C_HILO_HI   = 2'b10;
    localparam logic [1:0] C_HILO_BOTH = 2'b11;

    // Divider state encodings
    localparam logic [1:0] C_DIV_IDLE = 2'd0;
    localparam logic [1:0] C_DIV_CALC = 2'd1;
    localparam logic [1:0] C_DIV_FIX  = 2'd2;
    localparam logic [1:0] C_DIV_DONE = 2'd3;

    // One quotient bit per CALC cycle
    localparam int unsigned C_DIV_ITERS     = 32;
    localparam logic [4:0]  C_DIV_LAST_ITER = 5'(C_DIV_ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = C_DIV_IDLE,
        S_CALC = C_DIV_CALC,
        S_FIX  = C_DIV_FIX,
        S_DONE = C_DIV_DONE
    } div_state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_div_unit_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : 32-bit iterative restoring divider (DIV/DIVU).
//               IDLE -> CALC (32 cycles) -> FIX -> DONE -> IDLE.
//               A start accepted in cycle T gives o_done in cycle T+34.
// Ports       : clk, resetn      clock / async active-low reset
//               i_start          request, sampled only in IDLE
//               i_signed         1 = DIV, 0 = DIVU (captured with start)
//               i_a, i_b         dividend / divisor (captured with start)
//               i_cancel         flush, forces IDLE at next edge
//               o_busy           high in CALC and FIX
//               o_done           one-cycle result-valid pulse
//               o_quot, o_rem    result, held until overwritten by FIX
// Revision    : 1.0  initial release
// ============================================================================
module div_iter
    import hilo_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cancel,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    div_state_e  r_state;
    div_state_e  w_state_next;
    logic        w_busy;
    logic        w_done;

    logic [4:0]  r_iter;
    logic [31:0] r_quo;      // dividend magnitude shifting out, quotient in
    logic [31:0] r_prem;     // partial remainder (low 32 bits)
    logic [31:0] r_b_mag;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_b_zero;
    logic [31:0] r_quot_out;
    logic [31:0] r_rem_out;

    logic        w_accept;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_part;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_accept = (r_state == S_IDLE) & i_start & ~i_cancel;
    assign w_a_mag  = (i_signed & i_a[31]) ? neg32(i_a) : i_a;
    assign w_b_mag  = (i_signed & i_b[31]) ? neg32(i_b) : i_b;

    // 33-bit partial remainder: previous remainder shifted left with the
    // next dividend bit. Whenever it is >= the divisor the true difference
    // is below 2^32, so a 32-bit subtract of the low bits is exact.
    assign w_part = {r_prem, r_quo[31]};
    assign w_ge   = (w_part >= {1'b0, r_b_mag});
    assign w_diff = w_part[31:0] - r_b_mag;

    // Division by zero bypasses the sign fix of the quotient; the remainder
    // path naturally yields |a| restored to the sign of a, i.e. a itself.
    assign w_q_fix = r_b_zero ? 32'hFFFF_FFFF : (r_neg_q ? neg32(r_quo) : r_quo);
    assign w_r_fix = r_neg_r ? neg32(r_prem) : r_prem;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_iter == C_DIV_LAST_ITER) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_busy       = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                // A flush in the DONE cycle kills the completion pulse
                w_done       = ~i_cancel;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (i_cancel) begin
            w_state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_iter     <= 5'd0;
            r_quo      <= 32'd0;
            r_prem     <= 32'd0;
            r_b_mag    <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_quot_out <= 32'd0;
            r_rem_out  <= 32'd0;
        end else if (i_cancel) begin
            r_iter <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_iter   <= 5'd0;
                        r_quo    <= w_a_mag;
                        r_prem   <= 32'd0;
                        r_b_mag  <= w_b_mag;
                        r_neg_q  <= i_signed & (i_a[31] ^ i_b[31]);
                        r_neg_r  <= i_signed & i_a[31];
                        r_b_zero <= (i_b == 32'd0);
                    end
                end
                S_CALC: begin
                    r_prem <= w_ge ? w_diff : w_part[31:0];
                    r_quo  <= {r_quo[30:0], w_ge};
                    r_iter <= r_iter + 5'd1;
                end
                S_FIX: begin
                    r_quot_out <= w_q_fix;
                    r_rem_out  <= w_r_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy = w_busy;
    assign o_done = w_done;
    assign o_quot = r_quot_out;
    assign o_rem  = r_rem_out;

endmodule
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit
// Description : HI/LO register pair with WB-stage write port, plus the
//               iterative DIV/DIVU unit. The divider only reports its result;
//               HI/LO are written exclusively through hilo_mode_wb.
// Ports       : clk, resetn            clock / async active-low reset
//               hilo_mode_wb           00 none, 01 LO, 10 HI, 11 both
//               rdata1_wb              MTHI/MTLO source
//               alu_r1_wb, alu_r2_wb   LO / HI results of MULT/DIV
//               div_start, div_signed, div_a, div_b, div_cancel
//               div_busy, div_done, div_quot, div_rem
//               hilo                   registered {HI,LO}
// Revision    : 1.0  initial release
// ============================================================================
module hilo_div_unit
    import hilo_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  hilo_mode_wb,
    input  logic [31:0] rdata1_wb,
    input  logic [31:0] alu_r1_wb,
    input  logic [31:0] alu_r2_wb,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    input  logic        div_cancel,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_quot,
    output logic [31:0] div_rem,
    output logic [63:0] hilo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            case (hilo_mode_wb)
                C_HILO_LO: r_lo <= rdata1_wb;
                C_HILO_HI: r_hi <= rdata1_wb;
                C_HILO_BOTH: begin
                    r_hi <= alu_r2_wb;
                    r_lo <= alu_r1_wb;
                end
                default: begin
                end
            endcase
        end
    end

    assign hilo = {r_hi, r_lo};

    div_iter u_div_iter (
        .clk      (clk),
        .resetn   (resetn),
        .i_start  (div_start),
        .i_signed (div_signed),
        .i_a      (div_a),
        .i_b      (div_b),
        .i_cancel (div_cancel),
        .o_busy   (div_busy),
        .o_done   (div_done),
        .o_quot   (div_quot),
        .o_rem    (div_rem)
    );

endmodule
`default_nettype wire
